seven_segment_scan_driver: RTL and testbench

//  Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits sharing one segment bus.

---
 rtl/seg7_pkg.sv | 25 ++
 rtl/seg7_glyph_decoder.sv | 35 +++
 rtl/seven_segment_scan_driver.sv | 124 ++++++++++++
 tb/tb_seven_segment_scan_driver.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared glyph constants and segment type for the 7-segment scan driver
// Segment patterns are active-low, bit0=a .. bit6=g.
package seg7_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t GLYPH_0     = 7'h40;
  localparam seg_t GLYPH_1     = 7'h79;
  localparam seg_t GLYPH_2     = 7'h24;
  localparam seg_t GLYPH_3     = 7'h30;
  localparam seg_t GLYPH_4     = 7'h19;
  localparam seg_t GLYPH_5     = 7'h12;
  localparam seg_t GLYPH_6     = 7'h02;
  localparam seg_t GLYPH_7     = 7'h78;
  localparam seg_t GLYPH_8     = 7'h00;
  localparam seg_t GLYPH_9     = 7'h10;
  localparam seg_t GLYPH_A     = 7'h08;
  localparam seg_t GLYPH_B     = 7'h03;
  localparam seg_t GLYPH_C     = 7'h46;
  localparam seg_t GLYPH_D     = 7'h21;
  localparam seg_t GLYPH_E     = 7'h06;
  localparam seg_t GLYPH_F     = 7'h0E;
  localparam seg_t GLYPH_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_glyph_decoder.sv
// rtl/seg7_glyph_decoder.sv - combinational nibble to active-low segment pattern
// Nibbles 10-15 render blank unless hex_mode is set.
module seg7_glyph_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  output seg_t       seg
);

  always_comb begin
    seg = GLYPH_BLANK;
    case (nibble)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
      default: seg = GLYPH_BLANK;
    endcase
    if (!hex_mode && (nibble > 4'h9)) seg = GLYPH_BLANK;
  end

endmodule

// File: rtl/seven_segment_scan_driver.sv
// rtl/seven_segment_scan_driver.sv - time-multiplexed, double-buffered 7-segment display driver
// New values are committed only at the frame boundary so a frame never mixes two values.
module seven_segment_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int HEX_MODE   = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    lz_en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_done
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = 5 * NUM_DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

  logic [CW-1:0]         count;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         shadow;
  logic [BW-1:0]         active;
  logic                  pending;
  logic                  tick;
  logic                  boundary;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic [NUM_DIGITS-1:0] an_next;
  logic [3:0]            nib;
  logic                  dp_sel;
  logic                  blank_sel;
  seg_t                  glyph;

  assign tick     = (count == CNT_LAST);
  assign boundary = tick && (idx == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      idx   <= '0;
    end else begin
      count <= tick ? '0 : count + 1'b1;
      if (tick) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the boundary bypasses the shadow so it shows in the frame that starts now.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load) shadow <= {dp_in, value_in};
      if (boundary) begin
        pending <= 1'b0;
        if (load)         active <= {dp_in, value_in};
        else if (pending) active <= shadow;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  // lead_zero[i]: nibbles NUM_DIGITS-1 down to i are all zero.
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (active[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      lead_zero[i] = lead_zero[i+1] && (active[4*i +: 4] == 4'h0);
    end
  end

  always_comb begin
    nib       = '0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    an_next   = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        nib        = active[4*i +: 4];
        dp_sel     = active[4*NUM_DIGITS + i];
        blank_sel  = lz_en && (i > 0) && lead_zero[i];
        an_next[i] = 1'b0;
      end
    end
  end

  seg7_glyph_decoder u_decoder (
    .nibble   (nib),
    .hex_mode (HEX_MODE != 0),
    .seg      (glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_n      <= GLYPH_BLANK;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary;
      if (!en) begin
        an_n  <= '1;
        seg_n <= GLYPH_BLANK;
        dp_n  <= 1'b1;
      end else begin
        an_n  <= an_next;
        seg_n <= blank_sel ? GLYPH_BLANK : glyph;
        dp_n  <= !dp_sel;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// tb/tb_seven_segment_scan_driver.sv - self-checking bench for seven_segment_scan_driver
// Two instances share stimulus: one decimal-only, one with hex glyphs.
module tb_seven_segment_scan_driver;

  logic        clk = 1'b0;
  logic        clk_run = 1'b0;
  logic        rst_n, en, lz_en, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_n0, seg_n1;
  logic        dp_n0, dp_n1;
  logic [3:0]  an_n0, an_n1;
  logic        fd0, fd1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dp;
    logic            lz;
    logic [3:0][6:0] seg0;
    logic [3:0][6:0] seg1;
    logic [3:0]      dpn;
  } vec_t;

  typedef struct {
    int         digit;
    logic [3:0] an;
    logic [6:0] seg0;
    logic [6:0] seg1;
    logic       dpn;
  } exp_t;

  exp_t sb[$];
  vec_t vt[7];

  always #5 if (clk_run) clk = ~clk;

  seven_segment_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .load(load),
    .value_in(value_in), .dp_in(dp_in),
    .seg_n(seg_n0), .dp_n(dp_n0), .an_n(an_n0), .frame_done(fd0)
  );

  seven_segment_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .lz_en(lz_en), .load(load),
    .value_in(value_in), .dp_in(dp_in),
    .seg_n(seg_n1), .dp_n(dp_n1), .an_n(an_n1), .frame_done(fd1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_digit(input int d, input logic [6:0] s0, input logic [6:0] s1, input logic dpn);
    exp_t e;
    e.digit = d;
    e.an    = ~(4'b0001 << d);
    e.seg0  = s0;
    e.seg1  = s1;
    e.dpn   = dpn;
    sb.push_back(e);
  endtask

  task automatic push_uniform(input logic [6:0] s);
    for (int d = 0; d < 4; d++) push_digit(d, s, s, 1'b1);
  endtask

  task automatic sample_digit();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty");
    end else begin
      e = sb.pop_front();
      chk($sformatf("an_n0 digit%0d", e.digit), 32'(an_n0), 32'(e.an));
      chk($sformatf("an_n1 digit%0d", e.digit), 32'(an_n1), 32'(e.an));
      chk($sformatf("seg_n0 digit%0d", e.digit), 32'(seg_n0), 32'(e.seg0));
      chk($sformatf("seg_n1 digit%0d", e.digit), 32'(seg_n1), 32'(e.seg1));
      chk($sformatf("dp_n digit%0d", e.digit), 32'(dp_n0), 32'(e.dpn));
    end
  endtask

  // Returns on the negedge where frame_done is high; digit 0 of the new frame appears next edge.
  task automatic wait_fd();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fd0 && n < 40);
    if (!fd0) begin
      checks++;
      failures++;
      $display("FAIL wait_frame_done timeout after %0d cycles", n);
    end
  endtask

  task automatic sample_frame();
    for (int d = 0; d < 4; d++) begin
      if (d == 0) @(negedge clk);
      else repeat (4) @(negedge clk);
      sample_digit();
    end
  endtask

  task automatic pulse_load(input logic [15:0] v, input logic [3:0] dp);
    value_in = v;
    dp_in    = dp;
    load     = 1'b1;
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    int n;
    vt[0] = '{16'h1234, 4'b0000, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111};
    vt[1] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vt[2] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
    vt[3] = '{16'h00A0, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h08, 7'h40}, 4'b1111};
    vt[4] = '{16'h89EF, 4'b0101, 1'b0, {7'h00, 7'h10, 7'h7F, 7'h7F}, {7'h00, 7'h10, 7'h06, 7'h0E}, 4'b1010};
    vt[5] = '{16'h0B0C, 4'b1000, 1'b1, {7'h7F, 7'h7F, 7'h40, 7'h7F}, {7'h7F, 7'h03, 7'h40, 7'h46}, 4'b0111};
    vt[6] = '{16'h5678, 4'b0010, 1'b1, {7'h12, 7'h02, 7'h78, 7'h00}, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1101};

    rst_n = 1'b1; en = 1'b1; lz_en = 1'b0; load = 1'b0; value_in = '0; dp_in = '0;

    // Asynchronous reset with the clock stopped.
    #2 rst_n = 1'b0;
    #1;
    chk("reset seg_n", 32'(seg_n0), 32'h7F);
    chk("reset an_n", 32'(an_n0), 32'hF);
    chk("reset dp_n", 32'(dp_n0), 32'h1);
    chk("reset frame_done", 32'(fd0), 32'h0);
    #1 rst_n = 1'b1;
    clk_run = 1'b1;

    @(negedge clk);
    chk("post-reset an_n idx0", 32'(an_n0), 32'hE);
    chk("post-reset seg_n idx0", 32'(seg_n0), 32'h40);
    repeat (3) @(negedge clk);
    chk("idx0 held 4 clks", 32'(an_n0), 32'hE);
    @(negedge clk);
    chk("idx1 after 4 clks", 32'(an_n0), 32'hD);

    // frame_done is a single-cycle pulse every 16 clocks.
    wait_fd();
    @(negedge clk);
    chk("frame_done width", 32'(fd0), 32'h0);
    n = 1;
    while (!fd0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("frame_done period", 32'(n), 32'd16);

    for (int v = 0; v < 7; v++) begin
      lz_en = vt[v].lz;
      for (int d = 0; d < 4; d++) push_digit(d, vt[v].seg0[d], vt[v].seg1[d], vt[v].dpn[d]);
      pulse_load(vt[v].value, vt[v].dp);
      wait_fd();
      sample_frame();
    end

    // Double buffering: loads mid-frame must not disturb the frame on screen.
    lz_en = 1'b0;
    wait_fd();
    repeat (4) @(negedge clk);
    pulse_load(16'h1111, 4'b0000);
    @(negedge clk);
    pulse_load(16'h2222, 4'b0000);
    push_digit(2, 7'h02, 7'h02, 1'b1);
    push_digit(3, 7'h12, 7'h12, 1'b1);
    repeat (2) @(negedge clk);
    sample_digit();
    repeat (4) @(negedge clk);
    sample_digit();
    push_uniform(7'h24);
    wait_fd();
    sample_frame();

    // Load on the boundary cycle shows in the frame starting there.
    wait_fd();
    repeat (15) @(negedge clk);
    push_uniform(7'h30);
    pulse_load(16'h3333, 4'b0000);
    chk("bypass boundary frame_done", 32'(fd0), 32'h1);
    sample_frame();

    // Display disable mid-frame; scanning continues underneath.
    wait_fd();
    repeat (5) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("en=0 an_n", 32'(an_n0), 32'hF);
    chk("en=0 seg_n", 32'(seg_n0), 32'h7F);
    chk("en=0 dp_n", 32'(dp_n0), 32'h1);
    repeat (6) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("en=1 resumes at idx3", 32'(an_n0), 32'h7);
    chk("en=1 seg_n idx3", 32'(seg_n0), 32'h30);

    // Mid-scan reset clears outputs immediately and the active value.
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midscan reset an_n", 32'(an_n0), 32'hF);
    chk("midscan reset seg_n", 32'(seg_n0), 32'h7F);
    chk("midscan reset dp_n", 32'(dp_n0), 32'h1);
    #1 rst_n = 1'b1;
    push_uniform(7'h40);
    wait_fd();
    sample_frame();

    chk("scoreboard drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
